fpdiv_arb: RTL and testbench

Shares one combinational `fpdiv` single-precision (RNE) divider among `NREQ` requesters, one accepted operation per cycle. Arbitration is round-robin; operands and tag are registered into a single issue stage, and each requester has a one-entry response buffer. The block sits between the functional units that need division and the existing `fpdiv` datapath, and instantiates that datapath internally.

---
 rtl/fpdiv_pkg.sv | 20 ++
 rtl/fpdiv_arb_if.sv | 27 ++
 rtl/fpdiv.sv | 81 ++++++++
 rtl/fpdiv_arb_rr_arbiter.sv | 34 +++
 rtl/fpdiv_arb.sv | 108 ++++++++++
 tb/tb_fpdiv_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and helpers for the shared fp32 divider and its requester arbiter.
package fpdiv_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  typedef struct packed {
    fp32_t n;
    fp32_t d;
  } fp_op_t;

  localparam fp32_t FP_QNAN = 32'h7fc0_0000;

  // Tag width for n requesters; a single requester pair still needs one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpdiv_arb_if.sv
// Requester-side bundle of the shared divider: request/response handshakes and occupancy.
interface fpdiv_arb_if
  import fpdiv_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_ready;
  fp32_t [NREQ-1:0]              req_n;
  fp32_t [NREQ-1:0]              req_d;
  logic [NREQ-1:0]               resp_valid;
  logic [NREQ-1:0]               resp_ready;
  fp32_t [NREQ-1:0]              resp_q;
  logic [$clog2(NREQ+1)-1:0]     in_flight;

  modport master (
    output req_valid, req_n, req_d, resp_ready,
    input  req_ready, resp_valid, resp_q, in_flight
  );

  modport slave (
    input  req_valid, req_n, req_d, resp_ready,
    output req_ready, resp_valid, resp_q, in_flight
  );

endinterface

// File: rtl/fpdiv.sv
// Combinational binary32 divider, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflowing results flush to zero.
module fpdiv
  import fpdiv_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t q
);

  logic              sign;
  logic [7:0]        a_exp;
  logic [7:0]        b_exp;
  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;
  logic [49:0]       num;
  logic [49:0]       den;
  logic [26:0]       quo;
  logic              rem_nz;
  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic [24:0]       mant_rnd;
  logic [22:0]       frac;
  logic signed [9:0] exp_pre;
  logic signed [9:0] exp_rnd;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_exp  = a[30:23];
    b_exp  = b[30:23];
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);
    a_inf  = (a_exp == 8'hff) && (a[22:0] == 23'h0);
    b_inf  = (b_exp == 8'hff) && (b[22:0] == 23'h0);
    a_nan  = (a_exp == 8'hff) && (a[22:0] != 23'h0);
    b_nan  = (b_exp == 8'hff) && (b[22:0] != 23'h0);

    // Mantissa ratio scaled by 2^26 leaves a guard bit plus sticky below the 24-bit result.
    num    = {1'b1, a[22:0], 26'h0};
    den    = {26'h0, 1'b1, b[22:0]};
    quo    = 27'(num / den);
    rem_nz = ((num % den) != 50'h0);

    exp_pre = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
    if (quo[26]) begin
      mant   = quo[26:3];
      guard  = quo[2];
      sticky = rem_nz | quo[1] | quo[0];
    end else begin
      mant    = quo[25:2];
      guard   = quo[1];
      sticky  = rem_nz | quo[0];
      exp_pre = exp_pre - 10'sd1;
    end

    mant_rnd = {1'b0, mant} + {24'h0, guard & (sticky | mant[0])};
    if (mant_rnd[24]) begin
      exp_rnd = exp_pre + 10'sd1;
      frac    = mant_rnd[23:1];
    end else begin
      exp_rnd = exp_pre;
      frac    = mant_rnd[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      q = FP_QNAN;
    end else if (a_inf || b_zero) begin
      q = {sign, 8'hff, 23'h0};
    end else if (a_zero || b_inf) begin
      q = {sign, 31'h0};
    end else if (exp_rnd >= 10'sd255) begin
      q = {sign, 8'hff, 23'h0};
    end else if (exp_rnd <= 10'sd0) begin
      q = {sign, 31'h0};
    end else begin
      q = {sign, exp_rnd[7:0], frac};
    end
  end

endmodule

// File: rtl/fpdiv_arb_rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after ptr, wrapping; one-hot grant.
module rr_arbiter
  import fpdiv_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = tag_w(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic         found;
  logic [W-1:0] idx;

  // advance low suppresses any grant, e.g. while the owner is held in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < N; off++) begin
      idx = W'((int'(ptr) + off) % N);
      if (advance && !found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fpdiv_arb.sv
// Shares one fpdiv among NREQ requesters: round-robin accept, one issue register,
// and a one-entry response buffer per requester.
module fpdiv_arb
  import fpdiv_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic        clk,
  input logic        rst_n,
  fpdiv_arb_if.slave bus
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = $clog2(NREQ + 1);

  typedef logic [TW-1:0] tag_t;

  logic [NREQ-1:0]  pending_q, pending_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  fp32_t [NREQ-1:0] resp_buf_q, resp_buf_d;
  tag_t             rr_ptr_q, rr_ptr_d;
  logic             s1_valid_q, s1_valid_d;
  tag_t             s1_tag_q, s1_tag_d;
  fp_op_t           s1_op_q, s1_op_d;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  handshake;
  tag_t             grant_idx;
  logic             accept;
  fp32_t            div_q;
  logic [CW-1:0]    in_flight_cnt;

  assign eligible  = bus.req_valid & ~pending_q;
  assign handshake = resp_valid_q & bus.resp_ready;
  assign accept    = |grant;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .ptr       (rr_ptr_q),
    .advance   (rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  fpdiv u_fpdiv (
    .a (s1_op_q.n),
    .b (s1_op_q.d),
    .q (div_q)
  );

  // A grant can never target a pending requester, so set and clear never collide on one bit.
  always_comb begin
    pending_d    = (pending_q & ~handshake) | grant;
    resp_valid_d = resp_valid_q & ~handshake;
    resp_buf_d   = resp_buf_q;
    if (s1_valid_q) begin
      resp_valid_d[s1_tag_q] = 1'b1;
      resp_buf_d[s1_tag_q]   = div_q;
    end

    s1_valid_d = accept;
    s1_tag_d   = s1_tag_q;
    s1_op_d    = s1_op_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      s1_tag_d  = grant_idx;
      s1_op_d.n = bus.req_n[grant_idx];
      s1_op_d.d = bus.req_d[grant_idx];
      rr_ptr_d  = (grant_idx == tag_t'(NREQ - 1)) ? '0 : grant_idx + tag_t'(1);
    end
  end

  always_comb begin
    in_flight_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_flight_cnt = in_flight_cnt + CW'(pending_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      resp_valid_q <= '0;
      resp_buf_q   <= '0;
      rr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s1_op_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      resp_valid_q <= resp_valid_d;
      resp_buf_q   <= resp_buf_d;
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_op_q      <= s1_op_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_q     = resp_buf_q;
  assign bus.in_flight  = in_flight_cnt;

endmodule

// File: tb/tb_fpdiv_arb.sv
// Bench for fpdiv_arb: directed scenarios plus random traffic, checked by a
// scoreboard fed from a real-arithmetic divide model and a round-robin model.
module tb_fpdiv_arb;
  import fpdiv_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpdiv_arb_if #(.NREQ(N)) bus ();

  fpdiv_arb #(.NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] q;
    int          due;
  } sb_t;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   ptr_m = 0;
  sb_t  sbq[N][$];
  bit   seen[N];
  int   grant_log[$];

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Binary32 -> real through a hand-built double (normal operands only).
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] bits;
    bits = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(bits);
  endfunction

  // Positive real -> binary32 magnitude, RNE, flushing below the normal range.
  function automatic logic [31:0] r2f(input real v);
    logic [63:0] bits;
    logic [24:0] mr;
    logic [22:0] frac;
    int          e;
    bits = $realtobits(v);
    e    = int'(bits[62:52]) - 896;
    mr   = {2'b01, bits[51:29]} + 25'(bits[28] && ((|bits[27:0]) || bits[29]));
    if (mr[24]) begin
      e    = e + 1;
      frac = mr[23:1];
    end else begin
      frac = mr[22:0];
    end
    if (e >= 255) return 32'h7f80_0000;
    if (e <= 0) return 32'h0;
    return {1'b0, e[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [31:0] m;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 32'h7fc0_0000;
    if (a_inf || b_zero) return {s, 8'hff, 23'h0};
    if (a_zero || b_inf) return {s, 31'h0};
    m = r2f(f2r(a) / f2r(b));
    return {s, m[30:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          kind;
    logic        s;
    logic [22:0] m;
    kind = $urandom_range(0, 19);
    s    = 1'($urandom);
    m    = 23'($urandom);
    case (kind)
      0:       return {s, 31'h0};
      1:       return {s, 8'hff, 23'h0};
      2:       return {s, 8'hff, m | 23'h1};
      3:       return {s, 8'h00, m | 23'h1};
      default: return {s, 8'($urandom_range(100, 154)), m};
    endcase
  endfunction

  // Monitor: predict the grant, score responses, then advance the model for the coming edge.
  task automatic monitorStep();
    int          g;
    int          idx;
    int          busy;
    logic [N-1:0] exp_ready;
    sb_t         e;
    if (!rst_n) begin
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("rst_in_flight", 32'(bus.in_flight), 32'h0);
      for (int i = 0; i < N; i++) begin
        sbq[i].delete();
        seen[i] = 1'b0;
      end
      ptr_m = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && bus.req_valid[idx] && sbq[idx].size() == 0) g = idx;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));

      busy = 0;
      for (int i = 0; i < N; i++) if (sbq[i].size() > 0) busy = busy + 1;
      checkOutput("in_flight", 32'(bus.in_flight), 32'(busy));

      for (int i = 0; i < N; i++) begin
        if (bus.resp_valid[i]) begin
          if (sbq[i].size() == 0) begin
            checkOutput($sformatf("resp_spurious_%0d", i), 32'(bus.resp_valid[i]), 32'h0);
          end else begin
            if (!seen[i]) begin
              checkOutput($sformatf("resp_latency_%0d", i), 32'(cycle), 32'(sbq[i][0].due));
              seen[i] = 1'b1;
            end
            checkOutput($sformatf("resp_q_%0d", i), bus.resp_q[i], sbq[i][0].q);
            if (bus.resp_ready[i]) begin
              void'(sbq[i].pop_front());
              seen[i] = 1'b0;
            end
          end
        end else if (sbq[i].size() > 0 && cycle >= sbq[i][0].due) begin
          checkOutput($sformatf("resp_valid_due_%0d", i), 32'(bus.resp_valid[i]), 32'h1);
        end
      end

      if (g >= 0) begin
        e.q   = fp_ref(bus.req_n[g], bus.req_d[g]);
        e.due = cycle + 2;
        sbq[g].push_back(e);
        ptr_m = (g + 1) % N;
        grant_log.push_back(g);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitorStep();
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rready);
    bus.req_valid  = valid;
    bus.resp_ready = rready;
  endtask

  task automatic setOp(input int i, input logic [31:0] n, input logic [31:0] d);
    bus.req_n[i] = n;
    bus.req_d[i] = d;
  endtask

  task automatic randOps();
    for (int i = 0; i < N; i++) setOp(i, rand_fp(), rand_fp());
  endtask

  task automatic drain();
    applyStimulus('0, '1);
    repeat (6) nextCycle();
  endtask

  task automatic waitGrant(input int i);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1'b1;
    end
    if (!got) checkOutput($sformatf("grant_timeout_%0d", i), 32'h0, 32'h1);
  endtask

  task automatic singleOp(input int i, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] exp_q);
    setOp(i, n, d);
    applyStimulus(N'(1) << i, '1);
    waitGrant(i);
    nextCycle();
    applyStimulus('0, '1);
    @(negedge clk);
    checkOutput("single_in_flight_busy", 32'(bus.in_flight), 32'h1);
    @(negedge clk);
    checkOutput("single_resp_valid", 32'(bus.resp_valid[i]), 32'h1);
    checkOutput("single_resp_q", bus.resp_q[i], exp_q);
    @(negedge clk);
    checkOutput("single_in_flight_idle", 32'(bus.in_flight), 32'h0);
    nextCycle();
  endtask

  task automatic resetCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    checkOutput("async_rst_in_flight", 32'(bus.in_flight), 32'h0);
    checkOutput("async_rst_req_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) nextCycle();
  endtask

  initial begin
    int          log_start;
    int          others;
    int          ngrants;
    bit          have_held;
    logic [31:0] held;

    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.req_n      = '0;
    bus.req_d      = '0;
    repeat (3) nextCycle();
    checkOutput("reset_resp_q", 32'(|bus.resp_q), 32'h0);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] single op");
    singleOp(0, 32'h3f80_0000, 32'h4000_0000, 32'h3f00_0000);

    $display("[TB] full contention from reset");
    resetCycle();
    setOp(0, 32'h40c0_0000, 32'h4040_0000);
    setOp(1, 32'h4120_0000, 32'h40a0_0000);
    setOp(2, 32'h4080_0000, 32'h4000_0000);
    setOp(3, 32'h3f80_0000, 32'h4080_0000);
    applyStimulus('1, '1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("contention_grant", 32'(bus.req_ready), 32'(N'(1) << k));
      if (k == 2) checkOutput("contention_q0", bus.resp_q[0], 32'h4000_0000);
      if (k == 3) checkOutput("contention_q1", bus.resp_q[1], 32'h4000_0000);
    end
    nextCycle();
    applyStimulus('0, '1);
    drain();

    $display("[TB] wrap-around");
    singleOp(2, 32'h4000_0000, 32'h4000_0000, 32'h3f80_0000);
    setOp(0, 32'h4040_0000, 32'h3f80_0000);
    setOp(3, 32'hc100_0000, 32'h4080_0000);
    applyStimulus(4'b1001, '1);
    @(negedge clk);
    checkOutput("wrap_first", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    checkOutput("wrap_second", 32'(bus.req_ready), 32'h1);
    nextCycle();
    drain();
    applyStimulus(4'b0011, '1);
    @(negedge clk);
    checkOutput("wrap_ptr_at_1", 32'(bus.req_ready), 32'h2);
    nextCycle();
    drain();

    $display("[TB] backpressure");
    randOps();
    applyStimulus('1, 4'b1101);
    waitGrant(1);
    nextCycle();
    log_start = grant_log.size();
    have_held = 1'b0;
    held      = '0;
    for (int k = 0; k < 10; k++) begin
      randOps();
      @(negedge clk);
      checkOutput("bp_req_ready1", 32'(bus.req_ready[1]), 32'h0);
      if (bus.resp_valid[1]) begin
        if (!have_held) begin
          held      = bus.resp_q[1];
          have_held = 1'b1;
        end else begin
          checkOutput("bp_resp_q1_stable", bus.resp_q[1], held);
        end
      end
      nextCycle();
    end
    checkOutput("bp_resp_valid1", 32'(bus.resp_valid[1]), 32'h1);
    others = 0;
    for (int k = log_start; k < grant_log.size(); k++) if (grant_log[k] != 1) others = others + 1;
    checkOutput("bp_others_granted", 32'(others > 0), 32'h1);
    applyStimulus(4'b0010, '1);
    @(negedge clk);
    checkOutput("bp_handshake_no_grant", 32'(bus.req_ready[1]), 32'h0);
    @(negedge clk);
    checkOutput("bp_regrant", 32'(bus.req_ready), 32'h2);
    nextCycle();
    drain();

    $display("[TB] divide by zero");
    singleOp(2, 32'h3f80_0000, 32'h0000_0000, 32'h7f80_0000);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      randOps();
      applyStimulus(N'($urandom), N'($urandom) | N'($urandom));
      nextCycle();
    end
    drain();

    $display("[TB] reset mid-flight");
    randOps();
    applyStimulus(4'b0111, '0);
    ngrants = 0;
    for (int k = 0; k < 20 && ngrants < 3; k++) begin
      @(negedge clk);
      if (|bus.req_ready) ngrants = ngrants + 1;
    end
    checkOutput("midflight_three_grants", 32'(ngrants), 32'h3);
    nextCycle();
    checkOutput("midflight_buffers_full", 32'($countones(bus.resp_valid)), 32'h2);
    resetCycle();
    applyStimulus(4'b1010, '1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_lowest", 32'(bus.req_ready), 32'h2);
    nextCycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
